// File: rtl/spi_response_transmitter_if.sv
// Host-facing SPI data line plus the response request/status handshake.
// Carries io BusyHold only when SPI_RESP_BUSY_TOKEN_EN is defined.
interface spi_response_transmitter_if;
    logic        SPI_CLK;
    logic        SPI_CS;
    logic        SPI_DO;
    logic        Start;
    logic [7:0]  R1;
    logic        Extended;
    logic [31:0] Payload;
    logic        Busy;
    logic        Done;
`ifdef SPI_RESP_BUSY_TOKEN_EN
    logic        BusyHold;
`endif

    // Command-layer / host side
    modport master (
`ifdef SPI_RESP_BUSY_TOKEN_EN
        output BusyHold,
`endif
        output SPI_CLK, SPI_CS, Start, R1, Extended, Payload,
        input  SPI_DO, Busy, Done
    );

    // Transmitter side
    modport slave (
`ifdef SPI_RESP_BUSY_TOKEN_EN
        input  BusyHold,
`endif
        input  SPI_CLK, SPI_CS, Start, R1, Extended, Payload,
        output SPI_DO, Busy, Done
    );
endinterface

// File: rtl/spi_response_transmitter.sv
// SD-card SPI-mode response transmitter: NCR filler bytes, then R1 or R1+32-bit payload, MSB first.
// Optional busy-token phase after R1-only responses when SPI_RESP_BUSY_TOKEN_EN is defined.
module spi_response_transmitter #(
    parameter int unsigned NCR_BYTES = 1
) (
    input logic                       clock,
    input logic                       reset,
    spi_response_transmitter_if.slave io
);

    localparam int unsigned SHIFT_W   = 40;
    localparam int unsigned BIT_CNT_W = 6;
    localparam int unsigned NCR_CNT_W = 7;

    localparam logic [BIT_CNT_W-1:0] LEN_R1   = BIT_CNT_W'(8);
    localparam logic [BIT_CNT_W-1:0] LEN_EXT  = BIT_CNT_W'(SHIFT_W);
    localparam logic [BIT_CNT_W-1:0] MSB_IDX  = BIT_CNT_W'(SHIFT_W - 1);
    localparam logic [NCR_CNT_W-1:0] NCR_LAST = NCR_CNT_W'(8 * NCR_BYTES - 1);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_NCR     = 2'd1;
    localparam logic [1:0] ST_SEND    = 2'd2;
`ifdef SPI_RESP_BUSY_TOKEN_EN
    localparam logic [1:0] ST_BUSYTOK = 2'd3;
`endif

    logic [1:0]           state_q,   state_d;
    logic [NCR_CNT_W-1:0] ncr_cnt_q, ncr_cnt_d;
    logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [SHIFT_W-1:0]   shift_q,   shift_d;
    logic                 ext_q,     ext_d;
    logic                 do_q,      do_d;
    logic                 busy_q,    busy_d;
    logic                 done_q,    done_d;

    logic sync_meta_q, sync_q, sync_prev_q;

    logic                 fall_c;
    logic                 finish_c;
    logic [BIT_CNT_W-1:0] bit_len_c;
    logic [BIT_CNT_W-1:0] bit_idx_c;

    assign fall_c    = sync_prev_q & ~sync_q;
    assign bit_len_c = ext_q ? LEN_EXT : LEN_R1;
    assign bit_idx_c = MSB_IDX - bit_cnt_q;

    // Next-state, counter and output decode
    always_comb begin
        state_d   = state_q;
        ncr_cnt_d = ncr_cnt_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        ext_d     = ext_q;
        do_d      = do_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        finish_c  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                do_d   = 1'b1;
                busy_d = 1'b0;
                // done_q blocks a start in the same cycle as the completion pulse
                if (io.Start && !io.SPI_CS && !done_q) begin
                    shift_d   = {io.R1, io.Payload};
                    ext_d     = io.Extended;
                    ncr_cnt_d = '0;
                    bit_cnt_d = '0;
                    busy_d    = 1'b1;
                    state_d   = ST_NCR;
                end
            end

            ST_NCR: begin
                do_d = 1'b1;
                if (fall_c) begin
                    if (ncr_cnt_q == NCR_LAST) begin
                        ncr_cnt_d = '0;
                        state_d   = ST_SEND;
                    end else begin
                        ncr_cnt_d = ncr_cnt_q + NCR_CNT_W'(1);
                    end
                end
            end

            ST_SEND: begin
                if (fall_c) begin
                    if (bit_cnt_q == bit_len_c) begin
`ifdef SPI_RESP_BUSY_TOKEN_EN
                        if (!ext_q && io.BusyHold) begin
                            do_d    = 1'b0;
                            state_d = ST_BUSYTOK;
                        end else begin
                            finish_c = 1'b1;
                        end
`else
                        finish_c = 1'b1;
`endif
                    end else begin
                        do_d      = shift_q[bit_idx_c];
                        bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
                    end
                end
            end

`ifdef SPI_RESP_BUSY_TOKEN_EN
            ST_BUSYTOK: begin
                if (fall_c) begin
                    if (io.BusyHold) begin
                        do_d = 1'b0;
                    end else begin
                        finish_c = 1'b1;
                    end
                end
            end
`endif

            default: begin
                state_d = ST_IDLE;
                do_d    = 1'b1;
                busy_d  = 1'b0;
            end
        endcase

        if (finish_c) begin
            state_d   = ST_IDLE;
            do_d      = 1'b1;
            busy_d    = 1'b0;
            done_d    = 1'b1;
            bit_cnt_d = '0;
            ncr_cnt_d = '0;
        end

        // Host deselect abandons the response without a completion pulse
        if ((state_q != ST_IDLE) && io.SPI_CS) begin
            state_d   = ST_IDLE;
            do_d      = 1'b1;
            busy_d    = 1'b0;
            done_d    = 1'b0;
            bit_cnt_d = '0;
            ncr_cnt_d = '0;
        end
    end

    // State, datapath, registered outputs and SPI_CLK synchroniser
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            ncr_cnt_q   <= '0;
            bit_cnt_q   <= '0;
            shift_q     <= '1;
            ext_q       <= 1'b0;
            do_q        <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            sync_meta_q <= 1'b0;
            sync_q      <= 1'b0;
            sync_prev_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ncr_cnt_q   <= ncr_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            ext_q       <= ext_d;
            do_q        <= do_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            sync_meta_q <= io.SPI_CLK;
            sync_q      <= sync_meta_q;
            sync_prev_q <= sync_q;
        end
    end

    assign io.SPI_DO = do_q;
    assign io.Busy   = busy_q;
    assign io.Done   = done_q;

endmodule

// File: tb/tb_spi_response_transmitter.sv
// Self-checking bench for spi_response_transmitter: table vectors, random responses, and
// hand-built abort/reset/ignored-start sequences; busy-token case when SPI_RESP_BUSY_TOKEN_EN is set.
module tb_spi_response_transmitter;

    localparam int NCR = 1;
    localparam int NCR_BITS = 8 * NCR;

    logic clock;
    logic reset;

    int n_asserts = 0;
    int n_fail    = 0;
    int done_cnt  = 0;

    spi_response_transmitter_if io ();

    spi_response_transmitter #(.NCR_BYTES(NCR)) dut (
        .clock (clock),
        .reset (reset),
        .io    (io.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Completion pulse counter, sampled away from the active edge
    always @(negedge clock) begin
        if (io.Done === 1'b1) done_cnt++;
    end

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation did not finish, time %0t required end before 900000", $time);
        $fatal(1);
    end

    typedef struct {
        logic [7:0]  r1;
        logic        ext;
        logic [31:0] pl;
        int          exp_len;
        logic [39:0] exp_word;
        int          exp_done_edge;
    } vec_t;

    vec_t tbl[4];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_asserts++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h required 0x%0h", nm, act, exp);
        end
    endtask

    // One full SPI_CLK period; returns once the falling edge has had time to propagate
    task automatic spi_edge();
        io.SPI_CLK = 1'b1;
        repeat (4) @(negedge clock);
        io.SPI_CLK = 1'b0;
        repeat (5) @(negedge clock);
    endtask

    // Expected DO after falling edge k (1-based) of a response transmitting word[39 -: len]
    function automatic logic model_do(input int k, input logic [39:0] word, input int len);
        int j;
        if (k <= NCR_BITS) return 1'b1;
        j = k - NCR_BITS - 1;
        if (j < len) return word[39 - j];
        return 1'b1;
    endfunction

    task automatic start_req(input string nm, input logic [7:0] r1, input logic ext,
                             input logic [31:0] pl, input logic exp_busy);
        io.R1 = r1; io.Extended = ext; io.Payload = pl; io.Start = 1'b1;
        @(negedge clock);
        io.Start = 1'b0;
        // Scramble request inputs so a missing latch shows up in the stream
        io.R1 = 8'($urandom); io.Payload = $urandom; io.Extended = ~ext;
        chk({nm, ".busy_after_start"}, 64'(io.Busy), 64'(exp_busy));
    endtask

    task automatic stream(input string nm, input logic [39:0] word, input int len,
                          input int done_edge, input int k_from, input int k_to);
        int d0;
        for (int k = k_from; k <= k_to; k++) begin
            d0 = done_cnt;
            spi_edge();
            chk($sformatf("%s.do_e%0d", nm, k), 64'(io.SPI_DO), 64'(model_do(k, word, len)));
            chk($sformatf("%s.done_e%0d", nm, k), 64'(done_cnt - d0), 64'(k == done_edge));
            if (k == done_edge) chk($sformatf("%s.busy_end", nm), 64'(io.Busy), 64'd0);
        end
    endtask

    initial begin
        logic [7:0]  r1;
        logic        ext;
        logic [31:0] pl;
        int          len;
        int          d0;
        int          waited;

        tbl[0] = '{8'h01, 1'b0, 32'h0000_0000, 8,  40'h01_0000_0000, 17};
        tbl[1] = '{8'h01, 1'b1, 32'h0000_01AA, 40, 40'h01_0000_01AA, 49};
        tbl[2] = '{8'hA5, 1'b0, 32'hDEAD_BEEF, 8,  40'hA5_0000_0000, 17};
        tbl[3] = '{8'hC0, 1'b1, 32'hFF00_FF00, 40, 40'hC0_FF00_FF00, 49};

        reset = 1'b1;
        io.SPI_CLK = 1'b0; io.SPI_CS = 1'b1; io.Start = 1'b0;
        io.R1 = 8'h00; io.Extended = 1'b0; io.Payload = 32'h0;
`ifdef SPI_RESP_BUSY_TOKEN_EN
        io.BusyHold = 1'b0;
`endif
        repeat (3) @(negedge clock);
        chk("reset.do",   64'(io.SPI_DO), 64'd1);
        chk("reset.busy", 64'(io.Busy),   64'd0);
        chk("reset.done", 64'(io.Done),   64'd0);
        reset = 1'b0;
        io.SPI_CS = 1'b0;
        @(negedge clock);

        // Falling edges while idle keep DO high
        for (int i = 0; i < 2; i++) begin
            spi_edge();
            chk("idle.do", 64'(io.SPI_DO), 64'd1);
        end

        // Start while deselected is ignored
        io.SPI_CS = 1'b1;
        start_req("cs_high_start", 8'h00, 1'b0, 32'h0, 1'b0);
        io.SPI_CS = 1'b0;
        @(negedge clock);

        for (int v = 0; v < 4; v++) begin
            start_req($sformatf("tbl%0d", v), tbl[v].r1, tbl[v].ext, tbl[v].pl, 1'b1);
            stream($sformatf("tbl%0d", v), tbl[v].exp_word, tbl[v].exp_len,
                   tbl[v].exp_done_edge, 1, tbl[v].exp_done_edge + 1);
        end

        for (int n = 0; n < 6; n++) begin
            r1 = 8'($urandom); ext = 1'($urandom); pl = $urandom;
            len = ext ? 40 : 8;
            start_req($sformatf("rnd%0d", n), r1, ext, pl, 1'b1);
            stream($sformatf("rnd%0d", n), {r1, pl}, len, NCR_BITS + len + 1,
                   1, NCR_BITS + len + 2);
        end

        // Second start mid-response is ignored
        start_req("ign", 8'h01, 1'b0, 32'h0, 1'b1);
        stream("ign", 40'h01_0000_0000, 8, 17, 1, 5);
        start_req("ign2", 8'h05, 1'b1, 32'h1234_5678, 1'b1);
        stream("ign", 40'h01_0000_0000, 8, 17, 6, 20);
        chk("ign.busy_idle", 64'(io.Busy), 64'd0);

        // Deselect after 12 falling edges aborts
        start_req("abort", 8'h00, 1'b0, 32'h0, 1'b1);
        stream("abort", 40'h00_0000_0000, 8, 17, 1, 12);
        chk("abort.do_before", 64'(io.SPI_DO), 64'd0);
        d0 = done_cnt;
        io.SPI_CS = 1'b1;
        @(negedge clock);
        chk("abort.do",   64'(io.SPI_DO), 64'd1);
        chk("abort.busy", 64'(io.Busy),   64'd0);
        repeat (10) @(negedge clock);
        chk("abort.no_done", 64'(done_cnt - d0), 64'd0);
        io.SPI_CS = 1'b0;
        @(negedge clock);
        start_req("abort_next", 8'h00, 1'b0, 32'h0, 1'b1);
        stream("abort_next", 40'h00_0000_0000, 8, 17, 1, 18);

        // Reset mid-payload discards the transfer
        start_req("rst", 8'h3C, 1'b1, 32'h0000_0000, 1'b1);
        stream("rst", 40'h3C_0000_0000, 40, 49, 1, 30);
        d0 = done_cnt;
        reset = 1'b1;
        @(negedge clock);
        chk("rst.do",   64'(io.SPI_DO), 64'd1);
        chk("rst.busy", 64'(io.Busy),   64'd0);
        chk("rst.done", 64'(io.Done),   64'd0);
        reset = 1'b0;
        repeat (3) @(negedge clock);
        chk("rst.no_done", 64'(done_cnt - d0), 64'd0);
        start_req("rst_next", 8'h01, 1'b0, 32'h0, 1'b1);
        stream("rst_next", 40'h01_0000_0000, 8, 17, 1, 18);

        // Start presented in the Done cycle is ignored; one presented afterwards is accepted
        start_req("dcyc", 8'h81, 1'b0, 32'h0, 1'b1);
        stream("dcyc", 40'h81_0000_0000, 8, 17, 1, 16);
        io.SPI_CLK = 1'b1;
        repeat (4) @(negedge clock);
        io.SPI_CLK = 1'b0;
        waited = 0;
        @(negedge clock);
        while (io.Done !== 1'b1 && waited < 10) begin
            @(negedge clock);
            waited++;
        end
        chk("dcyc.done_seen", 64'(io.Done), 64'd1);
        start_req("dcyc_same", 8'h55, 1'b0, 32'h0, 1'b0);
        start_req("dcyc_next", 8'h55, 1'b0, 32'h0, 1'b1);
        stream("dcyc_next", 40'h55_0000_0000, 8, 17, 1, 18);

`ifdef SPI_RESP_BUSY_TOKEN_EN
        // Busy token: DO low while BusyHold, then high with completion
        io.BusyHold = 1'b1;
        start_req("btok", 8'h00, 1'b0, 32'h0, 1'b1);
        stream("btok", 40'h00_0000_0000, 8, 100, 1, 16);
        for (int i = 0; i < 5; i++) begin
            d0 = done_cnt;
            spi_edge();
            chk($sformatf("btok.hold_do%0d", i), 64'(io.SPI_DO), 64'd0);
            chk($sformatf("btok.hold_done%0d", i), 64'(done_cnt - d0), 64'd0);
        end
        io.BusyHold = 1'b0;
        d0 = done_cnt;
        spi_edge();
        chk("btok.release_do",   64'(io.SPI_DO), 64'd1);
        chk("btok.release_done", 64'(done_cnt - d0), 64'd1);
        chk("btok.release_busy", 64'(io.Busy), 64'd0);
`endif

        repeat (4) @(negedge clock);
        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_response_transmitter.md
SPI_RESPONSE_TRANSMITTER -- requirements
Module: spi_response_transmitter

Interface
REQ-001 Parameter: NCR_BYTES, default 1, count of 0xFF filler bytes driven before the response (legal 1..8).
REQ-002 clock  input  1  system clock; one clock, runs at >=4x SPI_CLK frequency.
REQ-003 reset  input  1  reset, synchronous, active-high.
REQ-004 io_SPI_CLK  input  1  SPI clock from host, asynchronous to clock, idle low (mode 0).
REQ-005 io_SPI_CS  input  1  chip select from host, active-low.
REQ-006 io_SPI_DO  output  1  card-to-host data line, idle high.
REQ-007 io_Start  input  1  single-cycle request to send a response.
REQ-008 io_R1  input  8  R1 status byte.
REQ-009 io_Extended  input  1  1 = R3/R7 format (R1 followed by 32-bit payload), 0 = R1 only.
REQ-010 io_Payload  input  32  R3/R7 payload (OCR or voltage/check-pattern word).
REQ-011 io_Busy  output  1  high from accepted start until completion or abort.
REQ-012 io_Done  output  1  one-cycle pulse on successful completion.

Function
REQ-013 The block SHALL synchronise io_SPI_CLK through two flops and detect a falling edge as previous-synced=1, current-synced=0.
REQ-014 io_SPI_DO SHALL be a registered output that changes only in the clock cycle following a detected SPI_CLK falling edge, so the host samples it on the next rising edge.
REQ-015 States: IDLE, NCR, SEND, BUSYTOK (only with macro, see Configuration), and back to IDLE.
REQ-016 IDLE: io_SPI_DO=1, io_Busy=0; io_Start=1 with io_SPI_CS=0 latches io_R1, io_Extended and io_Payload, sets io_Busy=1 in the next cycle, and enters NCR.
REQ-017 io_Start while io_Busy=1 or io_SPI_CS=1 SHALL be ignored; the latched data is not altered.
REQ-018 NCR: io_SPI_DO holds 1 for exactly 8*NCR_BYTES falling edges, then enters SEND.
REQ-019 SEND: each falling edge drives the next bit MSB-first: R1[7..0], then Payload[31..0] when Extended=1; total 8 or 40 bits.
REQ-020 A 6-bit bit counter SHALL index the 40-bit shift register; it does not wrap and terminates at 8 or 40.
REQ-021 On the falling edge after the last bit, io_SPI_DO SHALL return to 1, io_Done SHALL pulse for one cycle, io_Busy SHALL clear, and the state SHALL return to IDLE.
REQ-022 io_Done and a new accepted io_Start SHALL NOT occur in the same cycle; a start is accepted at the earliest one cycle after io_Done.
REQ-023 io_SPI_CS=1 in any non-IDLE state SHALL abort within one cycle: state IDLE, io_SPI_DO=1, io_Busy=0, no io_Done pulse.
REQ-024 Falling edges while in IDLE SHALL leave io_SPI_DO at 1.

Reset
REQ-025 reset=1 at a rising clock edge SHALL force state IDLE, io_SPI_DO=1, io_Busy=0, io_Done=0, counters=0, shift register=0xFF..FF, and synchroniser flops=0.
REQ-026 Reset mid-response SHALL discard the transfer without an io_Done pulse; the first start after reset release SHALL be accepted normally.

Configuration
REQ-027 Macro SPI_RESP_BUSY_TOKEN_EN: when defined, input io_BusyHold (1 bit) exists; after the last bit of an R1-only response with io_BusyHold=1, the block enters BUSYTOK and drives io_SPI_DO=0 on each falling edge while io_BusyHold=1; the first falling edge with io_BusyHold=0 drives 1 and completes per REQ-021.
REQ-028 When the macro is undefined, io_BusyHold and BUSYTOK are absent and completion always follows REQ-021 directly.

Verification
REQ-029 NCR_BYTES=1, Start with R1=0x01, Extended=0 -> 8 ones, then 0000_0001 on DO, Done pulse on 17th falling edge, Busy low afterwards.
REQ-030 Start with R1=0x01, Extended=1, Payload=0x000001AA -> 8 ones, then 0x01, then 0x000001AA MSB-first (40 bits); Done on 49th falling edge.
REQ-031 Start with R1=0x05 while sending the previous response -> second request ignored; DO stream matches the first response only.
REQ-032 CS raised after 12 falling edges of an R1=0x00 response -> DO=1 and Busy=0 within one cycle, no Done; the next Start with R1=0x00 completes normally.
REQ-033 reset asserted mid-payload of an Extended response -> DO=1, Busy=0, Done=0 next cycle; the subsequent R1=0x01 response is correct.
REQ-034 With SPI_RESP_BUSY_TOKEN_EN, R1=0x00, BusyHold high for 5 falling edges after the last bit -> DO=0 for those 5 edges, then 1 with a Done pulse.
